// File: rtl/sram_emulator_pkg.sv
// ============================================================================
// Module   : sram_emulator_pkg
// Brief    : Shared FSM encodings and counter width for the SRAM emulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sram_emulator_pkg;

  localparam int C_CNT_BITS   = 16;
  localparam int C_STATE_BITS = 2;

  typedef logic [C_STATE_BITS-1:0] state_t;

  localparam logic [C_STATE_BITS-1:0] C_IDLE         = 2'd0;
  localparam logic [C_STATE_BITS-1:0] C_READ         = 2'd1;
  localparam logic [C_STATE_BITS-1:0] C_WRITE_LOW    = 2'd2;
  localparam logic [C_STATE_BITS-1:0] C_WRITE_COMMIT = 2'd3;

endpackage

`default_nettype wire

// File: rtl/sram_emulator_mem.sv
// ============================================================================
// Module   : sram_emulator_mem
// Brief    : Single-port synchronous RAM, write-first, registered read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_emulator_mem #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] wdata,
  output logic [DATA_BITS-1:0] rdata
);

  localparam int C_DEPTH = 2 ** ADDR_BITS;

  // The array carries no reset so it maps onto block RAM.
  logic [DATA_BITS-1:0] r_mem [C_DEPTH];
  logic [DATA_BITS-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        r_mem[addr] <= wdata;
        r_rdata     <= wdata;
      end else begin
        r_rdata     <= r_mem[addr];
      end
    end
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/sram_emulator.sv
// ============================================================================
// Module   : sram_emulator
// Brief    : Responder-side SRAM pin emulator with access counters and
//            optional protocol checks (enabled by SRAM_EMULATOR_CHECK_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_emulator
  import sram_emulator_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_BITS-1:0]  addr_bus,
  inout  wire  [DATA_BITS-1:0]  data_bus_io,
  input  logic                  we_n,
  input  logic                  oe_n,
  input  logic                  ce_n,
  output logic [C_CNT_BITS-1:0] wr_count,
  output logic [C_CNT_BITS-1:0] rd_count,
  output logic                  err_contention,
  output logic                  err_we_oe
);

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_drive_en;
  logic [ADDR_BITS-1:0]  r_cap_addr;
  logic [DATA_BITS-1:0]  r_cap_data;
  logic [C_CNT_BITS-1:0] r_wr_count;
  logic [C_CNT_BITS-1:0] r_rd_count;

  logic                  w_read_go;
  logic                  w_capture;
  logic                  w_commit;
  logic                  w_mem_en;
  logic [ADDR_BITS-1:0]  w_mem_addr;
  logic [DATA_BITS-1:0]  w_mem_rdata;

  always_comb begin
    w_next_state = r_state;
    if (ce_n) begin
      w_next_state = C_IDLE;
    end else begin
      case (r_state)
        C_IDLE, C_WRITE_COMMIT: begin
          if (!we_n)      w_next_state = C_WRITE_LOW;
          else if (!oe_n) w_next_state = C_READ;
          else            w_next_state = C_IDLE;
        end
        C_READ: begin
          if (!we_n)      w_next_state = C_WRITE_LOW;
          else if (oe_n)  w_next_state = C_IDLE;
          else            w_next_state = C_READ;
        end
        C_WRITE_LOW: begin
          if (we_n)       w_next_state = C_WRITE_COMMIT;
          else            w_next_state = C_WRITE_LOW;
        end
        default:          w_next_state = C_IDLE;
      endcase
    end
  end

  assign w_read_go = (w_next_state == C_READ);
  assign w_capture = (w_next_state == C_WRITE_LOW);

  // The array is written on the edge that enters WRITE_COMMIT, which leaves
  // the single RAM port free for a read issued while leaving WRITE_COMMIT.
  assign w_commit   = (r_state == C_WRITE_LOW) && (w_next_state == C_WRITE_COMMIT);
  assign w_mem_en   = w_read_go || w_commit;
  assign w_mem_addr = w_commit ? r_cap_addr : addr_bus;

  sram_emulator_mem #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS)
  ) u_mem (
    .clk   (clk),
    .en    (w_mem_en),
    .we    (w_commit),
    .addr  (w_mem_addr),
    .wdata (r_cap_data),
    .rdata (w_mem_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= C_IDLE;
      r_drive_en <= 1'b0;
      r_cap_addr <= '0;
      r_cap_data <= '0;
      r_wr_count <= '0;
      r_rd_count <= '0;
    end else begin
      r_state    <= w_next_state;
      r_drive_en <= w_read_go;
      if (w_capture) begin
        r_cap_addr <= addr_bus;
        r_cap_data <= data_bus_io;
      end
      if (r_state == C_WRITE_COMMIT) begin
        r_wr_count <= r_wr_count + C_CNT_BITS'(1);
      end
      if (w_read_go) begin
        r_rd_count <= r_rd_count + C_CNT_BITS'(1);
      end
    end
  end

  assign data_bus_io = r_drive_en ? w_mem_rdata : {DATA_BITS{1'bz}};
  assign wr_count    = r_wr_count;
  assign rd_count    = r_rd_count;

`ifdef SRAM_EMULATOR_CHECK_EN
  logic r_err_contention;
  logic r_err_we_oe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_contention <= 1'b0;
      r_err_we_oe      <= 1'b0;
    end else begin
      if (!we_n && r_drive_en) begin
        r_err_contention <= 1'b1;
      end
      if (!we_n && !oe_n && !ce_n) begin
        r_err_we_oe <= 1'b1;
      end
    end
  end

  assign err_contention = r_err_contention;
  assign err_we_oe      = r_err_we_oe;
`else
  assign err_contention = 1'b0;
  assign err_we_oe      = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_emulator.sv
// ============================================================================
// Module   : tb_sram_emulator
// Brief    : Directed self-checking bench for sram_emulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_emulator;
  import sram_emulator_pkg::*;

`ifdef SRAM_EMULATOR_CHECK_EN
  localparam logic C_ERR_EXP = 1'b1;
`else
  localparam logic C_ERR_EXP = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [7:0]  addr_bus;
  wire  [15:0] data_bus;
  logic        we_n;
  logic        oe_n;
  logic        ce_n;
  logic [15:0] wr_count;
  logic [15:0] rd_count;
  logic        err_contention;
  logic        err_we_oe;

  logic [15:0] tb_drv;
  logic        tb_drv_en;

  int checks;
  int failures;

  assign data_bus = tb_drv_en ? tb_drv : 16'hzzzz;

  sram_emulator #(
    .ADDR_BITS (8),
    .DATA_BITS (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .addr_bus       (addr_bus),
    .data_bus_io    (data_bus),
    .we_n           (we_n),
    .oe_n           (oe_n),
    .ce_n           (ce_n),
    .wr_count       (wr_count),
    .rd_count       (rd_count),
    .err_contention (err_contention),
    .err_we_oe      (err_we_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b1;
    ce_n      = 1'b1;
    oe_n      = 1'b1;
    we_n      = 1'b1;
    addr_bus  = 8'h00;
    tb_drv    = 16'h0000;
    tb_drv_en = 1'b0;
    tick();
    tick();
    check("rst_state", 32'(dut.r_state), 32'(C_IDLE));
    check("rst_drive", 32'(dut.r_drive_en), 32'd0);
    check("rst_wr", 32'(wr_count), 32'd0);
    check("rst_rd", 32'(rd_count), 32'd0);
    check("rst_errc", 32'(err_contention), 32'd0);
    check("rst_erro", 32'(err_we_oe), 32'd0);
    reset = 1'b0;

    // Selected but idle for five cycles
    ce_n = 1'b0;
    repeat (5) tick();
    check("idle_state", 32'(dut.r_state), 32'(C_IDLE));
    check("idle_drive", 32'(dut.r_drive_en), 32'd0);
    check("idle_wr", 32'(wr_count), 32'd0);
    check("idle_rd", 32'(rd_count), 32'd0);

    // One-cycle write pulse: 0xBEEF -> 0x12
    addr_bus = 8'h12; tb_drv = 16'hBEEF; tb_drv_en = 1'b1; we_n = 1'b0;
    tick();
    check("wr1_state", 32'(dut.r_state), 32'(C_WRITE_LOW));
    check("wr1_drive", 32'(dut.r_drive_en), 32'd0);
    we_n = 1'b1;
    tick();
    check("wr1_commit_state", 32'(dut.r_state), 32'(C_WRITE_COMMIT));
    tb_drv_en = 1'b0;
    tick();
    check("wr1_count", 32'(wr_count), 32'd1);

    // Hold oe_n low at 0x12
    oe_n = 1'b0;
    tick();
    check("rd1_drive", 32'(dut.r_drive_en), 32'd1);
    check("rd1_data", 32'(data_bus), 32'hBEEF);
    check("rd1_count", 32'(rd_count), 32'd1);
    tick();
    check("rd2_data", 32'(data_bus), 32'hBEEF);
    check("rd2_count", 32'(rd_count), 32'd2);
    check("rd2_state", 32'(dut.r_state), 32'(C_READ));

    // Release oe_n, then start a write on the next cycle
    oe_n = 1'b1;
    tick();
    check("hz_drive", 32'(dut.r_drive_en), 32'd0);
    check("hz_state", 32'(dut.r_state), 32'(C_IDLE));
    check("hz_rd", 32'(rd_count), 32'd2);
    addr_bus = 8'h03; tb_drv = 16'h1234; tb_drv_en = 1'b1; we_n = 1'b0;
    tick();
    check("clean_errc", 32'(err_contention), 32'd0);
    check("clean_state", 32'(dut.r_state), 32'(C_WRITE_LOW));
    we_n = 1'b1;
    tick();
    tb_drv_en = 1'b0;
    tick();
    check("wr2_count", 32'(wr_count), 32'd2);

    // Back-to-back reads of two addresses
    oe_n = 1'b0;
    tick();
    check("b2b_data0", 32'(data_bus), 32'h1234);
    check("b2b_rd0", 32'(rd_count), 32'd3);
    addr_bus = 8'h12;
    tick();
    check("b2b_data1", 32'(data_bus), 32'hBEEF);
    check("b2b_rd1", 32'(rd_count), 32'd4);

    // we_n pulled low while the emulator drives the bus
    we_n = 1'b0;
    tick();
    check("cont_drive", 32'(dut.r_drive_en), 32'd0);
    check("cont_state", 32'(dut.r_state), 32'(C_WRITE_LOW));
    check("cont_errc", 32'(err_contention), 32'(C_ERR_EXP));
    check("cont_erro", 32'(err_we_oe), 32'(C_ERR_EXP));
    check("cont_rd", 32'(rd_count), 32'd4);
    // Second low sample carries the real data; the last sample must win
    tb_drv = 16'hCAFE; tb_drv_en = 1'b1; oe_n = 1'b1;
    tick();
    we_n = 1'b1;
    tick();
    tb_drv_en = 1'b0;
    tick();
    check("wr3_count", 32'(wr_count), 32'd3);
    oe_n = 1'b0;
    tick();
    check("wr3_data", 32'(data_bus), 32'hCAFE);
    check("wr3_rd", 32'(rd_count), 32'd5);
    check("sticky_errc", 32'(err_contention), 32'(C_ERR_EXP));
    oe_n = 1'b1;
    tick();

    // Write and read together (write wins), then reset mid-write
    addr_bus = 8'h03; tb_drv = 16'h5555; tb_drv_en = 1'b1; we_n = 1'b0; oe_n = 1'b0;
    tick();
    check("prio_state", 32'(dut.r_state), 32'(C_WRITE_LOW));
    check("prio_drive", 32'(dut.r_drive_en), 32'd0);
    check("prio_rd", 32'(rd_count), 32'd5);
    reset = 1'b1;
    #1;
    check("arst_state", 32'(dut.r_state), 32'(C_IDLE));
    check("arst_wr", 32'(wr_count), 32'd0);
    check("arst_rd", 32'(rd_count), 32'd0);
    check("arst_errc", 32'(err_contention), 32'd0);
    we_n = 1'b1; oe_n = 1'b1; tb_drv_en = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check("abort_wr", 32'(wr_count), 32'd0);
    oe_n = 1'b0;
    tick();
    check("abort_data", 32'(data_bus), 32'h1234);
    check("abort_rd", 32'(rd_count), 32'd1);

    // Deselect mid-read
    ce_n = 1'b1;
    tick();
    check("desel_drive", 32'(dut.r_drive_en), 32'd0);
    check("desel_state", 32'(dut.r_state), 32'(C_IDLE));
    check("desel_rd", 32'(rd_count), 32'd1);
    ce_n = 1'b0; oe_n = 1'b1;
    tick();

    // Preload the write counter near its top so the wrap needs few cycles
    force dut.r_wr_count = 16'hFFFD;
    #1;
    release dut.r_wr_count;
    tb_drv_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr_bus = 8'h40 + 8'(i);
      tb_drv   = 16'hA000 + 16'(i);
      we_n     = 1'b0;
      tick();
      we_n     = 1'b1;
      tick();
      if (i == 1) begin
        tick();
        check("wrap_pre", 32'(wr_count), 32'hFFFF);
      end
    end
    tb_drv_en = 1'b0;
    tick();
    check("wrap_zero", 32'(wr_count), 32'h0000);
    oe_n = 1'b0; addr_bus = 8'h42;
    tick();
    check("wrap_data", 32'(data_bus), 32'hA002);
    oe_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sram_emulator.md
SRAM_EMULATOR -- requirements
Module: sram_emulator

Interface
REQ-001 Parameter ADDR_BITS, default 8, is the address bus width; the array depth SHALL be 2**ADDR_BITS words.
REQ-002 Parameter DATA_BITS, default 16, SHALL be the data bus width.
REQ-003 Port clk, input, 1: rising-edge clock for all logic.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port addr_bus, input, ADDR_BITS: word address from the SRAM controller.
REQ-006 Port data_bus_io, inout, DATA_BITS: shared data bus, driven only while drive_en=1, otherwise high-Z.
REQ-007 Ports we_n, oe_n, ce_n, input, 1 each: active-low write enable, output enable and chip enable.
REQ-008 Port wr_count, output, 16: count of committed writes, wraps modulo 2**16.
REQ-009 Port rd_count, output, 16: count of read cycles serviced, wraps modulo 2**16.
REQ-010 Port err_contention, output, 1: sticky flag, we_n sampled low while the emulator drives the bus.
REQ-011 Port err_we_oe, output, 1: sticky flag, we_n and oe_n sampled low together with ce_n low.

Function
REQ-012 All bus inputs SHALL be sampled on the clk rising edge; the emulator is the responder end of the SRAM pin interface.
REQ-013 The FSM SHALL have exactly the states IDLE, READ, WRITE_LOW and WRITE_COMMIT.
REQ-014 Selection SHALL require ce_n=0; when ce_n=1 the FSM SHALL go to IDLE and drive_en SHALL clear on the same edge.
REQ-015 IDLE SHALL go to READ when oe_n=0 and we_n=1, go to WRITE_LOW when we_n=0, and otherwise stay in IDLE.
REQ-016 Entering or staying in READ SHALL register mem[addr_bus] onto the bus output and set drive_en, so data is valid one cycle after oe_n is first sampled low.
REQ-017 Each READ cycle SHALL increment rd_count by 1 and re-sample addr_bus, giving back-to-back reads one-cycle latency per word.
REQ-018 READ SHALL go to IDLE when oe_n=1 and to WRITE_LOW when we_n=0; drive_en SHALL clear on the edge where oe_n is first sampled high (one-cycle tHZOE model).
REQ-019 WRITE_LOW SHALL capture addr_bus and data_bus_io on every edge with we_n=0, so the last sample before release wins.
REQ-020 WRITE_LOW SHALL go to WRITE_COMMIT on the first edge with we_n=1.
REQ-021 WRITE_COMMIT SHALL write the captured data to the captured address, increment wr_count, and then apply the IDLE transition rules.
REQ-022 A write followed by a read of the same address SHALL return the newly written data.
REQ-023 drive_en SHALL never be 1 while the FSM is in WRITE_LOW or WRITE_COMMIT.
REQ-024 If we_n is sampled low while drive_en=1, the emulator SHALL clear drive_en on that edge and SHALL set err_contention.
REQ-025 When we_n=0 and oe_n=0, write SHALL take priority over read.

Reset
REQ-026 Reset SHALL set the FSM to IDLE and clear drive_en, wr_count, rd_count, err_contention, err_we_oe and the capture registers.
REQ-027 The memory array SHALL NOT be reset.
REQ-028 Reset asserted in WRITE_LOW SHALL discard the pending write with no array update.
REQ-029 data_bus_io SHALL be high-Z from reset assertion until the first qualified read.

Configuration
REQ-030 With SRAM_EMULATOR_CHECK_EN defined, err_contention and err_we_oe SHALL be generated as in REQ-010, REQ-011 and REQ-024.
REQ-031 Without SRAM_EMULATOR_CHECK_EN, both error outputs SHALL be constant 0; the contention release in REQ-024 still applies.

Structure
REQ-032 A shared package SHALL hold the FSM state encodings and the 16-bit counter width constant.
REQ-033 The array SHALL be a sub-module sram_emulator_mem: a single-port synchronous RAM, write-first, with registered read.

Verification
REQ-034 Reset, then inputs ce_n=0, oe_n=1, we_n=1 for 5 cycles -> bus high-Z, FSM in IDLE, both counters 0.
REQ-035 Write 0xBEEF to address 0x12 via a one-cycle we_n low pulse, then hold oe_n low at address 0x12 -> 0xBEEF on the bus one cycle later, wr_count=1, rd_count increments once per read cycle.
REQ-036 Read address 0x12, release oe_n and assert we_n on the next cycle -> drive_en drops on the oe_n-high edge, err_contention stays 0.
REQ-037 Hold oe_n low with the bus driven, then pull we_n low -> drive_en clears on that edge, and err_contention=1 with the macro defined or 0 without it.
REQ-038 Assert reset while we_n is low writing 0x5555 to address 0x03 -> address 0x03 keeps its prior value, wr_count=0.
REQ-039 Perform 65536 writes -> wr_count wraps to 0.
